// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register in front of the ALU.
// Captures a decoded instruction, resolves rs/rt through EX/MEM/WB forwarding,
// inserts a single bubble on a load-use hazard, and honours downstream
// stall (hold) and flush (bubble).
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   idValid/idReady     decode handshake (idReady is combinational)
//   id*                 decoded instruction fields and register-file data
//   aluOut              ALU result of the instruction held in this stage
//   mem*/wb*            MEM and WB forwarding sources
//   exStall, flush      downstream hold; kill the instruction being captured
//   exValid, aluInA/B, aluCode, exStoreData, exDstNum, exWrEnable, exIsLoad
//                       registered stage contents presented to the ALU
module alu_operand_stage #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CODE_WIDTH    = 4,
    parameter int unsigned REG_NUM_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     idValid,
    output logic                     idReady,
    input  logic [CODE_WIDTH-1:0]    idCode,
    input  logic [REG_NUM_WIDTH-1:0] idRsNum,
    input  logic [REG_NUM_WIDTH-1:0] idRtNum,
    input  logic                     idRsUsed,
    input  logic                     idRtUsed,
    input  logic [DATA_WIDTH-1:0]    idRsData,
    input  logic [DATA_WIDTH-1:0]    idRtData,
    input  logic [DATA_WIDTH-1:0]    idImm,
    input  logic                     idUseImm,
    input  logic [REG_NUM_WIDTH-1:0] idDstNum,
    input  logic                     idWrEnable,
    input  logic                     idIsLoad,
    input  logic [DATA_WIDTH-1:0]    aluOut,
    input  logic                     memWrEnable,
    input  logic [REG_NUM_WIDTH-1:0] memDstNum,
    input  logic [DATA_WIDTH-1:0]    memData,
    input  logic                     wbWrEnable,
    input  logic [REG_NUM_WIDTH-1:0] wbDstNum,
    input  logic [DATA_WIDTH-1:0]    wbData,
    input  logic                     exStall,
    input  logic                     flush,
    output logic                     exValid,
    output logic [DATA_WIDTH-1:0]    aluInA,
    output logic [DATA_WIDTH-1:0]    aluInB,
    output logic [CODE_WIDTH-1:0]    aluCode,
    output logic [DATA_WIDTH-1:0]    exStoreData,
    output logic [REG_NUM_WIDTH-1:0] exDstNum,
    output logic                     exWrEnable,
    output logic                     exIsLoad
);

    logic                     hazard;
    logic [DATA_WIDTH-1:0]    fwdRs;
    logic [DATA_WIDTH-1:0]    fwdRt;

    logic                     nxtValid;
    logic [DATA_WIDTH-1:0]    nxtInA;
    logic [DATA_WIDTH-1:0]    nxtInB;
    logic [CODE_WIDTH-1:0]    nxtCode;
    logic [DATA_WIDTH-1:0]    nxtStoreData;
    logic [REG_NUM_WIDTH-1:0] nxtDstNum;
    logic                     nxtWrEnable;
    logic                     nxtIsLoad;

    // Forwarding mux: EX (non-load, valid only) > MEM > WB > register file; r0 is zero.
    function automatic logic [DATA_WIDTH-1:0] fwdSel(
        input logic [REG_NUM_WIDTH-1:0] num,
        input logic [DATA_WIDTH-1:0]    fileData
    );
        logic [DATA_WIDTH-1:0] res;
        if (num == '0)
            res = '0;
        else if (exValid && exWrEnable && !exIsLoad && (exDstNum == num))
            res = aluOut;
        else if (memWrEnable && (memDstNum == num))
            res = memData;
        else if (wbWrEnable && (wbDstNum == num))
            res = wbData;
        else
            res = fileData;
        return res;
    endfunction

    // Load-use detection against the load currently held in this stage.
    always_comb begin
        hazard = exValid && exIsLoad && exWrEnable && (exDstNum != '0) &&
                 ((idRsUsed && (idRsNum == exDstNum)) ||
                  (idRtUsed && (idRtNum == exDstNum)));
        fwdRs  = fwdSel(idRsNum, idRsData);
        fwdRt  = fwdSel(idRtNum, idRtData);
    end

    assign idReady = !exStall && !hazard;

    // Next-state selection: flush > stall(hold) > hazard > capture > bubble.
    // Bubbles clear only the control bits; data registers keep their value.
    always_comb begin
        nxtValid     = exValid;
        nxtInA       = aluInA;
        nxtInB       = aluInB;
        nxtCode      = aluCode;
        nxtStoreData = exStoreData;
        nxtDstNum    = exDstNum;
        nxtWrEnable  = exWrEnable;
        nxtIsLoad    = exIsLoad;
        if (flush || (!exStall && (hazard || !idValid))) begin
            nxtValid    = 1'b0;
            nxtWrEnable = 1'b0;
            nxtIsLoad   = 1'b0;
        end else if (!exStall) begin
            nxtValid     = 1'b1;
            nxtInA       = fwdRs;
            nxtInB       = idUseImm ? idImm : fwdRt;
            nxtCode      = idCode;
            nxtStoreData = fwdRt;
            nxtDstNum    = idDstNum;
            nxtWrEnable  = idWrEnable;
            nxtIsLoad    = idIsLoad;
        end
    end

    // Stage register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exValid     <= 1'b0;
            aluInA      <= '0;
            aluInB      <= '0;
            aluCode     <= '0;
            exStoreData <= '0;
            exDstNum    <= '0;
            exWrEnable  <= 1'b0;
            exIsLoad    <= 1'b0;
        end else begin
            exValid     <= nxtValid;
            aluInA      <= nxtInA;
            aluInB      <= nxtInB;
            aluCode     <= nxtCode;
            exStoreData <= nxtStoreData;
            exDstNum    <= nxtDstNum;
            exWrEnable  <= nxtWrEnable;
            exIsLoad    <= nxtIsLoad;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: forwarding priority, load-use bubble,
// immediate operand, stall/flush and asynchronous reset.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        idValid;
    logic        idReady;
    logic [3:0]  idCode;
    logic [4:0]  idRsNum, idRtNum;
    logic        idRsUsed, idRtUsed;
    logic [31:0] idRsData, idRtData, idImm;
    logic        idUseImm;
    logic [4:0]  idDstNum;
    logic        idWrEnable, idIsLoad;
    logic [31:0] aluOut;
    logic        memWrEnable;
    logic [4:0]  memDstNum;
    logic [31:0] memData;
    logic        wbWrEnable;
    logic [4:0]  wbDstNum;
    logic [31:0] wbData;
    logic        exStall, flush;
    logic        exValid;
    logic [31:0] aluInA, aluInB, exStoreData;
    logic [3:0]  aluCode;
    logic [4:0]  exDstNum;
    logic        exWrEnable, exIsLoad;

    int checks   = 0;
    int failures = 0;

    alu_operand_stage dut (
        .clk(clk), .rst(rst),
        .idValid(idValid), .idReady(idReady), .idCode(idCode),
        .idRsNum(idRsNum), .idRtNum(idRtNum),
        .idRsUsed(idRsUsed), .idRtUsed(idRtUsed),
        .idRsData(idRsData), .idRtData(idRtData),
        .idImm(idImm), .idUseImm(idUseImm),
        .idDstNum(idDstNum), .idWrEnable(idWrEnable), .idIsLoad(idIsLoad),
        .aluOut(aluOut),
        .memWrEnable(memWrEnable), .memDstNum(memDstNum), .memData(memData),
        .wbWrEnable(wbWrEnable), .wbDstNum(wbDstNum), .wbData(wbData),
        .exStall(exStall), .flush(flush),
        .exValid(exValid), .aluInA(aluInA), .aluInB(aluInB), .aluCode(aluCode),
        .exStoreData(exStoreData), .exDstNum(exDstNum),
        .exWrEnable(exWrEnable), .exIsLoad(exIsLoad)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] code, input logic [4:0] rs, input logic [31:0] rsD,
                         input logic [4:0] rt, input logic [31:0] rtD, input logic [4:0] dst,
                         input logic wr, input logic ld);
        idValid    = 1'b1;
        idCode     = code;
        idRsNum    = rs;   idRsData = rsD; idRsUsed = 1'b1;
        idRtNum    = rt;   idRtData = rtD; idRtUsed = 1'b1;
        idUseImm   = 1'b0; idImm    = 32'h0;
        idDstNum   = dst;
        idWrEnable = wr;
        idIsLoad   = ld;
    endtask

    initial begin
        rst = 1'b0;
        idValid = 0; idCode = 0; idRsNum = 0; idRtNum = 0; idRsUsed = 0; idRtUsed = 0;
        idRsData = 0; idRtData = 0; idImm = 0; idUseImm = 0; idDstNum = 0;
        idWrEnable = 0; idIsLoad = 0; aluOut = 0;
        memWrEnable = 0; memDstNum = 0; memData = 0;
        wbWrEnable = 0; wbDstNum = 0; wbData = 0;
        exStall = 0; flush = 0;

        // Reset state
        #12;
        check("rst_exValid", 32'(exValid), 32'd0);
        check("rst_aluInA", aluInA, 32'd0);
        check("rst_aluInB", aluInB, 32'd0);
        check("rst_aluCode", 32'(aluCode), 32'd0);
        check("rst_storeData", exStoreData, 32'd0);
        check("rst_dstNum", 32'(exDstNum), 32'd0);
        check("rst_wrEnable", 32'(exWrEnable), 32'd0);
        check("rst_isLoad", 32'(exIsLoad), 32'd0);
        rst = 1'b1;
        step();
        check("rst_idReady", 32'(idReady), 32'd1);

        // EX forward: ADD r3 <- r1+r2, then SUB r4 <- r3-r1
        issue(4'd1, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1'b1, 1'b0);
        step();
        check("add_valid", 32'(exValid), 32'd1);
        check("add_inA", aluInA, 32'd5);
        check("add_inB", aluInB, 32'd7);
        check("add_dst", 32'(exDstNum), 32'd3);
        aluOut = 32'd12;
        issue(4'd2, 5'd3, 32'd0, 5'd1, 32'd5, 5'd4, 1'b1, 1'b0);
        step();
        check("exfwd_inA", aluInA, 32'd12);
        check("exfwd_inB", aluInB, 32'd5);
        check("exfwd_store", exStoreData, 32'd5);
        check("exfwd_code", 32'(aluCode), 32'd2);

        // Priority: EX/MEM/WB all target r6
        issue(4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd6, 1'b1, 1'b0);
        step();
        aluOut = 32'd1;
        memWrEnable = 1'b1; memDstNum = 5'd6; memData = 32'd2;
        wbWrEnable  = 1'b1; wbDstNum  = 5'd6; wbData  = 32'd3;
        issue(4'd0, 5'd6, 32'h99, 5'd0, 32'h55, 5'd6, 1'b1, 1'b0);
        step();
        check("prio_ex", aluInA, 32'd1);
        check("prio_rt_r0", aluInB, 32'd0);
        idValid = 1'b0;
        step();
        check("idle_bubble", 32'(exValid), 32'd0);
        check("idle_wr", 32'(exWrEnable), 32'd0);
        issue(4'd0, 5'd6, 32'h99, 5'd0, 32'h0, 5'd0, 1'b1, 1'b0);
        step();
        check("prio_mem", aluInA, 32'd2);
        memWrEnable = 1'b0;
        issue(4'd0, 5'd6, 32'h99, 5'd0, 32'h0, 5'd0, 1'b1, 1'b0);
        step();
        check("prio_wb", aluInA, 32'd3);
        memWrEnable = 1'b1; memDstNum = 5'd0;
        wbDstNum = 5'd0;
        issue(4'd0, 5'd0, 32'h77, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        check("prio_r0", aluInA, 32'd0);
        memWrEnable = 1'b0; wbWrEnable = 1'b0;

        // Load-use: LW r8, then AND using r8
        issue(4'd0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd8, 1'b1, 1'b1);
        idRtUsed = 1'b0;
        step();
        check("lw_isLoad", 32'(exIsLoad), 32'd1);
        issue(4'd4, 5'd8, 32'h0, 5'd0, 32'h0, 5'd10, 1'b1, 1'b0);
        idRtUsed = 1'b0;
        #1;
        check("hazard_idReady", 32'(idReady), 32'd0);
        step();
        check("hazard_bubble", 32'(exValid), 32'd0);
        check("hazard_bubble_ld", 32'(exIsLoad), 32'd0);
        check("after_bubble_idReady", 32'(idReady), 32'd1);
        memWrEnable = 1'b1; memDstNum = 5'd8; memData = 32'h1234;
        step();
        check("loaduse_memfwd", aluInA, 32'h1234);
        check("loaduse_valid", 32'(exValid), 32'd1);
        memWrEnable = 1'b0;

        // Immediate / shift amount
        issue(4'd3, 5'd0, 32'h0, 5'd9, 32'hABCD, 5'd11, 1'b1, 1'b0);
        idUseImm = 1'b1; idImm = 32'd4;
        step();
        check("sll_inB", aluInB, 32'd4);
        check("sll_store", exStoreData, 32'hABCD);
        check("sll_code", 32'(aluCode), 32'd3);

        // Stall for 3 cycles holds everything
        exStall = 1'b1;
        issue(4'd5, 5'd1, 32'h11, 5'd2, 32'h22, 5'd12, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_idReady", 32'(idReady), 32'd0);
            step();
            check("stall_inB", aluInB, 32'd4);
            check("stall_code", 32'(aluCode), 32'd3);
            check("stall_valid", 32'(exValid), 32'd1);
        end
        flush = 1'b1;
        step();
        check("flush_over_stall", 32'(exValid), 32'd0);
        flush = 1'b0; exStall = 1'b0;

        // Asynchronous reset with a valid instruction held
        issue(4'd6, 5'd1, 32'h55, 5'd2, 32'h66, 5'd13, 1'b1, 1'b0);
        step();
        check("pre_rst_valid", 32'(exValid), 32'd1);
        check("pre_rst_inA", aluInA, 32'h55);
        idValid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(exValid), 32'd0);
        check("async_rst_inA", aluInA, 32'd0);
        check("async_rst_dst", 32'(exDstNum), 32'd0);
        check("async_rst_wr", 32'(exWrEnable), 32'd0);
        #2 rst = 1'b1;
        step();
        check("post_rst_idReady", 32'(idReady), 32'd1);
        check("post_rst_valid", 32'(exValid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register in front of the ALU.
- Captures a decoded instruction, resolves operands by forwarding from EX/MEM/WB, and presents registered aluInA/aluInB/aluCode to the ALU.
- Detects load-use hazards, inserts one bubble per hazard, and supports downstream stall and flush.

Parameters:
DATA_WIDTH, 32, operand/result width (matches `DataPath).
CODE_WIDTH, 4, ALU opcode width (matches `ALUCodePath).
REG_NUM_WIDTH, 5, register index width; register 0 is hard-wired zero.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-low.
idValid  in  1  decode offers an instruction.
idReady  out  1  stage accepts it this cycle (combinational).
idCode  in  CODE_WIDTH  ALU operation.
idRsNum, idRtNum  in  REG_NUM_WIDTH  source register indices.
idRsUsed, idRtUsed  in  1  source actually read.
idRsData, idRtData  in  DATA_WIDTH  register-file read data.
idImm  in  DATA_WIDTH  extended immediate or shift amount.
idUseImm  in  1  operand B = idImm instead of rt.
idDstNum  in  REG_NUM_WIDTH  destination index.
idWrEnable  in  1  instruction writes a register.
idIsLoad  in  1  instruction is a load.
aluOut  in  DATA_WIDTH  current ALU result for the instruction held here.
memWrEnable, memDstNum, memData  in  1/REG_NUM_WIDTH/DATA_WIDTH  MEM-stage forward source; memData is final, including load data.
wbWrEnable, wbDstNum, wbData  in  1/REG_NUM_WIDTH/DATA_WIDTH  WB forward source.
exStall  in  1  downstream cannot advance; hold contents.
flush  in  1  kill the instruction being captured.
exValid  out  1  registered instruction valid.
aluInA, aluInB  out  DATA_WIDTH  registered ALU operands.
aluCode  out  CODE_WIDTH  registered opcode.
exStoreData  out  DATA_WIDTH  registered forwarded rt value.
exDstNum  out  REG_NUM_WIDTH  registered destination index.
exWrEnable, exIsLoad  out  1  registered control bits.

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs = 0; exValid=0. idReady=1 after release.
- Forwarding per source s ∈ {rs, rt}, evaluated at capture, highest priority first:
  - (1) exValid & exWrEnable & !exIsLoad & exDstNum==sNum → aluOut.
  - (2) memWrEnable & memDstNum==sNum → memData.
  - (3) wbWrEnable & wbDstNum==sNum → wbData.
  - (4) otherwise register-file data.
  - sNum==0 always yields 0, regardless of forwarding or file data.
- Load-use hazard:
  - Condition: hazard = exValid & exIsLoad & exWrEnable & exDstNum!=0 & ((idRsUsed & idRsNum==exDstNum) | (idRtUsed & idRtNum==exDstNum)).
  - Response: the next edge loads a bubble (exValid←0, exWrEnable←0, exIsLoad←0; data regs don't-care).
  - idReady=0 that cycle; decode holds. The following cycle forwards from MEM.
- idReady = !exStall & !hazard.
- Update priority on each edge:
  - flush → bubble, overriding both exStall and hazard.
  - else exStall → hold all registers.
  - else hazard → bubble.
  - else idValid → capture.
  - else → bubble.
- Capture loads:
  - aluInA ← fwd(rs).
  - aluInB ← idUseImm ? idImm : fwd(rt).
  - exStoreData ← fwd(rt).
  - aluCode, exDstNum, exWrEnable, exIsLoad ← id fields.
- Latency: operands are visible to the ALU exactly one cycle after the accept cycle (idValid & idReady).
- A bubble or flushed slot never drives forwarding: rule (1) is gated by exValid.
- Simultaneous exStall and hazard: the hold wins and idReady=0; the hazard is re-evaluated after the stall releases.
- Reset mid-stall clears everything immediately; no instruction survives.

Test Plan:
- Reset: rst=0 mid-operation with exValid=1 → all outputs 0 asynchronously; after release, idReady=1.
- EX forward: ADD r3←r1+r2 (r1=5, r2=7), then SUB r4←r3−r1 with file r3=0 → second cycle aluInA=12 (from aluOut), aluInB=5.
- Priority: EX, MEM, and WB all targeting r6 with 1/2/3 → aluInA=1. With EX invalid → 2. Targeting r0 → 0.
- Load-use: LW r8 followed by AND using r8 → idReady=0 for one cycle and one bubble (exValid=0). Next cycle aluInA=memData=0x1234.
- Immediate/shift: SLL with idUseImm=1, idImm=4, rt=r9 → aluInB=4, exStoreData=r9 value.
- Stall/flush: exStall=1 for 3 cycles → outputs unchanged, idReady=0. flush=1 during exStall → exValid=0 next edge.
